// File: rtl/tv80_reg_dump_pkg.sv
`default_nettype none
// ============================================================================
// Module   : tv80_reg_dump_pkg
// Brief    : Shared types and constants for the TV80 register-dump engine.
// Revision : 1.0
// ============================================================================
package tv80_reg_dump_pkg;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_HOLD    = 3'd1,
        S_CAPTURE = 3'd2,
        S_HDR     = 3'd3,
        S_DATA    = 3'd4,
        S_SUM     = 3'd5
    } dump_state_e;

    localparam logic [7:0] HDR_BYTE_DEFAULT = 8'hA5;
    localparam int         FRAME_LEN        = 18;

endpackage
`default_nettype wire

// File: rtl/tv80_reg_dump.sv
`default_nettype none
// ============================================================================
// Module   : tv80_reg_dump
// Brief    : Freezes the CPU, snapshots the 8 register pairs and streams them
//            out as header + 16 data bytes + checksum.
// Revision : 1.0
// ============================================================================
module tv80_reg_dump
    import tv80_reg_dump_pkg::*;
#(
    parameter int         HOLD_TIMEOUT = 255,
    parameter logic [7:0] HDR_BYTE     = HDR_BYTE_DEFAULT
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    output logic       hold_req,
    input  logic       hold_ack,
    output logic [2:0] reg_addr,
    input  logic [7:0] reg_dh,
    input  logic [7:0] reg_dl,
    output logic [7:0] tx_data,
    output logic       tx_valid,
    input  logic       tx_ready,
    output logic       busy,
    output logic       done,
    output logic       err
);

    localparam logic [7:0] TO_LAST = 8'(HOLD_TIMEOUT - 1);

    dump_state_e state_q, state_d;
    logic [3:0]  idx_q, idx_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [7:0]  chk_q, chk_d;
    logic        done_q, done_d;
    logic        err_q, err_d;
    logic        cap_we;
    logic [7:0]  cap_buf_q [16];

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        cnt_d    = cnt_q;
        chk_d    = chk_q;
        done_d   = 1'b0;
        err_d    = 1'b0;
        cap_we   = 1'b0;
        hold_req = 1'b0;
        reg_addr = 3'd0;
        tx_valid = 1'b0;
        tx_data  = 8'd0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_HOLD;
                    cnt_d   = 8'd0;
                    chk_d   = 8'd0;
                    idx_d   = 4'd0;
                end
            end
            S_HOLD: begin
                hold_req = 1'b1;
                if (hold_ack) begin
                    state_d = S_CAPTURE;
                    idx_d   = 4'd0;
                end else if (cnt_q == TO_LAST) begin
                    state_d = S_IDLE;
                    err_d   = 1'b1;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            S_CAPTURE: begin
                // Checksum is kept already negated so SUM can emit it directly.
                hold_req = 1'b1;
                reg_addr = idx_q[2:0];
                cap_we   = 1'b1;
                chk_d    = chk_q - reg_dh - reg_dl;
                idx_d    = idx_q + 4'd1;
                if (idx_q == 4'd7) begin
                    state_d = S_HDR;
                    idx_d   = 4'd0;
                end
            end
            S_HDR: begin
                tx_valid = 1'b1;
                tx_data  = HDR_BYTE;
                if (tx_ready) begin
                    state_d = S_DATA;
                    idx_d   = 4'd0;
                end
            end
            S_DATA: begin
                tx_valid = 1'b1;
                tx_data  = cap_buf_q[idx_q];
                if (tx_ready) begin
                    idx_d = idx_q + 4'd1;
                    if (idx_q == 4'd15) begin
                        state_d = S_SUM;
                    end
                end
            end
            S_SUM: begin
                tx_valid = 1'b1;
                tx_data  = chk_q;
                if (tx_ready) begin
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            idx_q   <= 4'd0;
            cnt_q   <= 8'd0;
            chk_q   <= 8'd0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            chk_q   <= chk_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    always_ff @(posedge clk) begin
        if (cap_we) begin
            cap_buf_q[{idx_q[2:0], 1'b0}] <= reg_dh;
            cap_buf_q[{idx_q[2:0], 1'b1}] <= reg_dl;
        end
    end

    assign busy = (state_q != S_IDLE);
    assign done = done_q;
    assign err  = err_q;

endmodule
`default_nettype wire
